cart_led_trigger: RTL
=====================

CART_LED_TRIGGER -- requirements
Module: cart_led_trigger

Purpose: upstream stage of the cart activity LED stretcher. Merges activity pulses into its trigger input and overrides them with a blink-coded error pattern.

Interface -- parameters
REQ-001 SHALL: TICK_DIV, 16'd62500, clock cycles per blink tick, range 2..65535.
REQ-002 SHALL: ON_TICKS, 8'd4, ticks per blink ON phase, range 1..255.
REQ-003 SHALL: OFF_TICKS, 8'd4, ticks per blink OFF phase, range 1..255.
REQ-004 SHALL: GAP_TICKS, 8'd16, ticks of pause between code repetitions, range 1..255.

Interface -- ports
REQ-005 SHALL: i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL: i_reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL: i_activity  input  4  per-source activity pulses (SD, USB, N64 bus, flash), synchronous to i_clk.
REQ-008 SHALL: i_error_valid  input  1  one-cycle strobe that loads i_error_code.
REQ-009 SHALL: i_error_code  input  4  blink count, 1..15; value 0 is ignored.
REQ-010 SHALL: i_error_clear  input  1  one-cycle strobe that leaves error mode.
REQ-011 SHALL: o_trigger  output  1  drives the LED stretcher trigger input.
REQ-012 SHALL: o_error_active  output  1  high while in any error state.

Function
REQ-013 SHALL: implement states NORMAL, ON, OFF, GAP; o_error_active = (state != NORMAL), registered.
REQ-014 SHALL: in NORMAL, o_trigger = registered OR of i_activity bits (latency 1 cycle, one output cycle per input cycle).
REQ-015 SHALL: free-running tick prescaler counts 0..TICK_DIV-1 and issues a tick when count == TICK_DIV-1, then wraps to 0.
REQ-016 SHALL: on i_error_valid with a nonzero code (any state), do all of the following: latch the code, set blink index to 1, zero the prescaler and phase counter, enter ON next cycle.
REQ-017 SHALL: treat i_error_valid with code 0 as a no-op.
REQ-018 SHALL: in ON, o_trigger = 1 every cycle; ON lasts exactly ON_TICKS*TICK_DIV cycles.
REQ-019 SHALL: at the end of ON, enter GAP if blink index == latched code, else enter OFF.
REQ-020 SHALL: in OFF, o_trigger = 0; OFF lasts OFF_TICKS*TICK_DIV cycles, then enter ON with blink index+1.
REQ-021 SHALL: in GAP, o_trigger = 0; GAP lasts GAP_TICKS*TICK_DIV cycles, then enter ON with blink index = 1 (pattern repeats indefinitely).
REQ-022 SHALL: ignore i_activity in ON, OFF and GAP.
REQ-023 SHALL: on i_error_clear, enter NORMAL next cycle with o_trigger = 0 that cycle; clear wins over a simultaneous i_error_valid.
REQ-024 SHALL: phase counter is 8 bits and blink index is 4 bits; neither wraps in legal operation.

Reset
REQ-025 SHALL: while i_reset_n = 0, immediately force state NORMAL, o_trigger 0, o_error_active 0, and all counters and the latched code to 0.
REQ-026 SHALL: resume operation on the first rising edge after reset deasserts; reset asserted mid-pattern aborts the pattern with no residual pulse.

Verification (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=6)
REQ-027 SHALL: i_activity=4'b0100 for 3 cycles in NORMAL -> o_trigger high for exactly 3 cycles, starting 1 cycle later.
REQ-028 SHALL: i_error_valid with code 2 at cycle t -> o_trigger pattern: high t+1..t+8, low t+9..t+16, high t+17..t+24, low t+25..t+48, high again at t+49; o_error_active high from t+1.
REQ-029 SHALL: code 3 loaded during OFF of a code-2 pattern -> ON restarts the next cycle with three blinks per repetition.
REQ-030 SHALL: i_error_valid (code 5) and i_error_clear in the same cycle -> NORMAL, o_error_active stays 0.
REQ-031 SHALL: i_error_valid with code 0 -> no state change; activity is still passed through.
REQ-032 SHALL: i_reset_n pulsed low mid-ON -> o_trigger and o_error_active drop asynchronously; block returns to NORMAL with activity pass-through.

Source files
------------

// File: rtl/cart_led_trigger.sv
// Cart activity LED trigger: merges per-source activity pulses and overrides
// them with a repeating blink-coded error pattern (N blinks, then a long gap).
//
// state     | meaning
// ----------|-------------------------------------------------
// ST_NORMAL | activity pass-through, no error latched
// ST_ON     | blink lit, trigger forced high
// ST_OFF    | dark between blinks of the same code
// ST_GAP    | long dark pause before the code repeats
module cart_led_trigger #(
    parameter logic [15:0] TICK_DIV  = 16'd62500,
    parameter logic [7:0]  ON_TICKS  = 8'd4,
    parameter logic [7:0]  OFF_TICKS = 8'd4,
    parameter logic [7:0]  GAP_TICKS = 8'd16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [3:0] i_activity,
    input  logic       i_error_valid,
    input  logic [3:0] i_error_code,
    input  logic       i_error_clear,
    output logic       o_trigger,
    output logic       o_error_active
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_ON     = 2'd1,
        ST_OFF    = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    localparam logic [15:0] TICK_LAST = TICK_DIV - 16'd1;
    localparam logic [7:0]  ON_LAST   = ON_TICKS - 8'd1;
    localparam logic [7:0]  OFF_LAST  = OFF_TICKS - 8'd1;
    localparam logic [7:0]  GAP_LAST  = GAP_TICKS - 8'd1;

    state_e      state_q, state_d;
    logic [3:0]  code_q, code_d;
    logic [3:0]  blink_q, blink_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  phase_q, phase_d;
    logic        trigger_q, trigger_d;
    logic        error_active_q, error_active_d;

    logic        tick;
    logic [7:0]  phase_last;
    logic        phase_done;

    always_comb begin
        tick = (presc_q == TICK_LAST);
        case (state_q)
            ST_ON:   phase_last = ON_LAST;
            ST_OFF:  phase_last = OFF_LAST;
            ST_GAP:  phase_last = GAP_LAST;
            default: phase_last = 8'd0;
        endcase
        phase_done = tick && (phase_q == phase_last);
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        blink_d = blink_q;
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        phase_d = phase_q;

        if (state_q != ST_NORMAL) begin
            if (phase_done) begin
                phase_d = 8'd0;
            end else if (tick) begin
                phase_d = phase_q + 8'd1;
            end
        end

        case (state_q)
            ST_ON: begin
                if (phase_done) begin
                    state_d = (blink_q == code_q) ? ST_GAP : ST_OFF;
                end
            end
            ST_OFF: begin
                if (phase_done) begin
                    state_d = ST_ON;
                    blink_d = blink_q + 4'd1;
                end
            end
            ST_GAP: begin
                if (phase_done) begin
                    state_d = ST_ON;
                    blink_d = 4'd1;
                end
            end
            default: ;
        endcase

        // Clear outranks a same-cycle load so software can always abort.
        if (i_error_clear) begin
            state_d = ST_NORMAL;
            blink_d = 4'd0;
            phase_d = 8'd0;
        end else if (i_error_valid && (i_error_code != 4'd0)) begin
            state_d = ST_ON;
            code_d  = i_error_code;
            blink_d = 4'd1;
            presc_d = 16'd0;
            phase_d = 8'd0;
        end

        trigger_d      = (state_d == ST_ON) ||
                         ((state_d == ST_NORMAL) && !i_error_clear && (|i_activity));
        error_active_d = (state_d != ST_NORMAL);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= ST_NORMAL;
            code_q         <= 4'd0;
            blink_q        <= 4'd0;
            presc_q        <= 16'd0;
            phase_q        <= 8'd0;
            trigger_q      <= 1'b0;
            error_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            blink_q        <= blink_d;
            presc_q        <= presc_d;
            phase_q        <= phase_d;
            trigger_q      <= trigger_d;
            error_active_q <= error_active_d;
        end
    end

    assign o_trigger      = trigger_q;
    assign o_error_active = error_active_q;

endmodule
